dhcp_vlg_lease: RTL and testbench

//  Lease lifecycle controller above the DHCP DORA core: issues DORA starts, holds the assigned IP,

---
 rtl/dhcp_vlg_lease.sv | 258 +++++++++++++++++++++++++
 tb/tb_dhcp_vlg_lease.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dhcp_vlg_lease.sv
// Lease lifecycle controller above a DHCP DORA core: acquire, hold, renew, rebind, expire, retry.
// Optional macro DHCP_VLG_LEASE_BACKOFF_EN doubles the ACQUIRE retry wait per failure, capped.
module dhcp_vlg_lease #(
  parameter int unsigned TICK_DIV      = 125000000,
  parameter int unsigned LEASE_W       = 32,
  parameter int unsigned RETRIES       = 4,
  parameter int unsigned RETRY_S       = 4,
  parameter int unsigned MAX_BACKOFF_S = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               init_i,
  output logic               dora_start_o,
  input  logic               dora_ok_i,
  input  logic               dora_fail_i,
  input  logic [31:0]        ip_in_i,
  input  logic [LEASE_W-1:0] lease_s_i,
  input  logic [LEASE_W-1:0] t1_s_i,
  input  logic               t1_val_i,
  input  logic [LEASE_W-1:0] t2_s_i,
  input  logic               t2_val_i,
  output logic [31:0]        ip_o,
  output logic               ip_val_o,
  output logic               renewing_o,
  output logic               expired_o,
  output logic               fail_o,
  output logic [2:0]         state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACQUIRE = 3'd1,
    S_BACKOFF = 3'd2,
    S_BOUND   = 3'd3,
    S_RENEW   = 3'd4,
    S_REBIND  = 3'd5,
    S_FAILED  = 3'd6
  } state_e;

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned RC_W  = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [LEASE_W-1:0] elapsed_q, elapsed_d;
  logic [LEASE_W-1:0] lease_q, lease_d;
  logic [LEASE_W-1:0] t1_q, t1_d;
  logic [LEASE_W-1:0] t2_q, t2_d;
  logic [31:0]        ip_q, ip_d;
  logic [31:0]        wait_q, wait_d;
  logic               rwait_q, rwait_d;
  logic [RC_W-1:0]    retry_q, retry_d;
  logic               start_req_q, start_req_d;
  logic               dora_start_q;
  logic               expired_q, expired_d;

  logic               tick;
  logic [LEASE_W-1:0] el_inc;
  logic [RC_W-1:0]    retry_inc;
  logic [31:0]        bo_wait;
  logic [31:0]        wait_inc;
  logic               enter_bound;
  logic               retry_step;

  logic [LEASE_W-1:0] lease_n, t1_def, t2_def, t1_c, t2_c, t1_n, t2_n;
  logic               opt_bad;

  assign tick      = (div_q == DIV_W'(TICK_DIV - 1));
  assign el_inc    = (tick && (elapsed_q != '1)) ? elapsed_q + 1'b1 : elapsed_q;
  assign retry_inc = retry_q + 1'b1;
  assign wait_inc  = wait_q + 32'd1;

  // Lease fields as they would be latched from the core this cycle.
  always_comb begin
    lease_n = (lease_s_i == '0) ? LEASE_W'(1) : lease_s_i;
    t1_def  = lease_n >> 1;
    t2_def  = lease_n - (lease_n >> 3);
    t1_c    = t1_val_i ? t1_s_i : t1_def;
    t2_c    = t2_val_i ? t2_s_i : t2_def;
    opt_bad = (t1_c >= t2_c) || (t2_c >= lease_n);
    t1_n    = opt_bad ? t1_def : t1_c;
    t2_n    = opt_bad ? t2_def : t2_c;
  end

`ifdef DHCP_VLG_LEASE_BACKOFF_EN
  logic [31:0] bo_shift;
  logic [63:0] bo_wide;
  always_comb begin
    bo_shift = 32'(retry_q) - 32'd1;
    bo_wide  = 64'(RETRY_S) << bo_shift[4:0];
    if ((bo_shift >= 32'd32) || (bo_wide > 64'(MAX_BACKOFF_S))) begin
      bo_wait = 32'(MAX_BACKOFF_S);
    end else begin
      bo_wait = bo_wide[31:0];
    end
  end
`else
  assign bo_wait = (RETRY_S > MAX_BACKOFF_S) ? 32'(MAX_BACKOFF_S) : 32'(RETRY_S);
`endif

  always_comb begin
    state_d     = state_q;
    div_d       = tick ? '0 : div_q + 1'b1;
    elapsed_d   = elapsed_q;
    lease_d     = lease_q;
    t1_d        = t1_q;
    t2_d        = t2_q;
    ip_d        = ip_q;
    wait_d      = wait_q;
    rwait_d     = rwait_q;
    retry_d     = retry_q;
    start_req_d = 1'b0;
    expired_d   = 1'b0;
    enter_bound = 1'b0;
    retry_step  = 1'b0;

    if (init_i) begin
      state_d     = S_ACQUIRE;
      retry_d     = '0;
      rwait_d     = 1'b0;
      start_req_d = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_ACQUIRE: begin
          if (dora_ok_i) begin
            enter_bound = 1'b1;
          end else if (dora_fail_i) begin
            retry_d = retry_inc;
            if (retry_inc == RC_W'(RETRIES)) begin
              state_d = S_FAILED;
            end else begin
              state_d = S_BACKOFF;
              wait_d  = '0;
              div_d   = '0;
            end
          end
        end
        S_BACKOFF: begin
          if (tick) begin
            if (wait_inc >= bo_wait) begin
              state_d     = S_ACQUIRE;
              start_req_d = 1'b1;
            end else begin
              wait_d = wait_inc;
            end
          end
        end
        S_BOUND: begin
          elapsed_d = el_inc;
          if ((lease_q != '1) && (el_inc >= t1_q)) begin
            state_d     = S_RENEW;
            rwait_d     = 1'b0;
            start_req_d = 1'b1;
          end
        end
        S_RENEW: begin
          elapsed_d = el_inc;
          if (dora_ok_i) begin
            enter_bound = 1'b1;
          end else if (el_inc >= t2_q) begin
            state_d     = S_REBIND;
            rwait_d     = 1'b0;
            start_req_d = 1'b1;
          end else begin
            retry_step = 1'b1;
          end
        end
        S_REBIND: begin
          elapsed_d = el_inc;
          if (dora_ok_i) begin
            enter_bound = 1'b1;
          end else if (el_inc >= lease_q) begin
            state_d     = S_ACQUIRE;
            expired_d   = 1'b1;
            retry_d     = '0;
            rwait_d     = 1'b0;
            start_req_d = 1'b1;
          end else begin
            retry_step = 1'b1;
          end
        end
        S_FAILED: ;
        default: state_d = S_IDLE;
      endcase
    end

    // Renew/rebind retry wait: elapsed keeps counting, thresholds above pre-empt it.
    if (retry_step) begin
      if (rwait_q) begin
        if (tick) begin
          if (wait_inc >= 32'(RETRY_S)) begin
            rwait_d     = 1'b0;
            start_req_d = 1'b1;
          end else begin
            wait_d = wait_inc;
          end
        end
      end else if (dora_fail_i) begin
        rwait_d = 1'b1;
        wait_d  = '0;
      end
    end

    if (enter_bound) begin
      state_d   = S_BOUND;
      ip_d      = ip_in_i;
      lease_d   = lease_n;
      t1_d      = t1_n;
      t2_d      = t2_n;
      elapsed_d = '0;
      div_d     = '0;
      retry_d   = '0;
      rwait_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      elapsed_q    <= '0;
      lease_q      <= '0;
      t1_q         <= '0;
      t2_q         <= '0;
      ip_q         <= '0;
      wait_q       <= '0;
      rwait_q      <= 1'b0;
      retry_q      <= '0;
      start_req_q  <= 1'b0;
      dora_start_q <= 1'b0;
      expired_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      elapsed_q    <= elapsed_d;
      lease_q      <= lease_d;
      t1_q         <= t1_d;
      t2_q         <= t2_d;
      ip_q         <= ip_d;
      wait_q       <= wait_d;
      rwait_q      <= rwait_d;
      retry_q      <= retry_d;
      start_req_q  <= start_req_d;
      dora_start_q <= start_req_q;
      expired_q    <= expired_d;
    end
  end

  assign dora_start_o = dora_start_q;
  assign ip_o         = ip_q;
  assign ip_val_o     = (state_q == S_BOUND) || (state_q == S_RENEW) || (state_q == S_REBIND);
  assign renewing_o   = (state_q == S_RENEW) || (state_q == S_REBIND);
  assign expired_o    = expired_q;
  assign fail_o       = (state_q == S_FAILED);
  assign state_o      = state_q;

endmodule

// File: tb/tb_dhcp_vlg_lease.sv
// Directed + randomized bench for dhcp_vlg_lease with a lease-timing reference model.
module tb_dhcp_vlg_lease;
  localparam int TD   = 4;
  localparam int RET  = 3;
  localparam int RS   = 2;
  localparam int MAXB = 64;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_ACQ = 3'd1, ST_BO = 3'd2, ST_BOUND = 3'd3,
                         ST_RENEW = 3'd4, ST_REBIND = 3'd5, ST_FAILED = 3'd6;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        init = 1'b0, dora_ok = 1'b0, dora_fail = 1'b0;
  logic [31:0] ip_in = '0, lease_s = '0, t1_s = '0, t2_s = '0;
  logic        t1_val = 1'b0, t2_val = 1'b0;
  logic        dora_start, ip_val, renewing, expired, fail;
  logic [31:0] ip;
  logic [2:0]  state;

  dhcp_vlg_lease #(.TICK_DIV(TD), .LEASE_W(32), .RETRIES(RET), .RETRY_S(RS),
                   .MAX_BACKOFF_S(MAXB)) dut (
    .clk_i(clk), .rst_i(rst), .init_i(init), .dora_start_o(dora_start),
    .dora_ok_i(dora_ok), .dora_fail_i(dora_fail), .ip_in_i(ip_in), .lease_s_i(lease_s),
    .t1_s_i(t1_s), .t1_val_i(t1_val), .t2_s_i(t2_s), .t2_val_i(t2_val),
    .ip_o(ip), .ip_val_o(ip_val), .renewing_o(renewing), .expired_o(expired),
    .fail_o(fail), .state_o(state)
  );

  // scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int bcyc    = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic int bo_w(input int k);
    int w;
    w = RS;
`ifdef DHCP_VLG_LEASE_BACKOFF_EN
    for (int i = 1; i < k; i++) w = w * 2;
`endif
    if (w > MAXB) w = MAXB;
    return w;
  endfunction

  task automatic model_times(input logic [31:0] l_in, input logic v1, input logic [31:0] o1,
                             input logic v2, input logic [31:0] o2,
                             output int l_o, output int t1_o, output int t2_o);
    longint l, d1, d2, c1, c2;
    l  = (l_in == 0) ? 1 : longint'(l_in);
    d1 = l / 2;
    d2 = l - l / 8;
    c1 = v1 ? longint'(o1) : d1;
    c2 = v2 ? longint'(o2) : d2;
    if (c1 >= c2 || c2 >= l) begin
      c1 = d1;
      c2 = d2;
    end
    l_o  = int'(l);
    t1_o = int'(c1);
    t2_o = int'(c2);
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_init();
    init = 1'b1;
    step();
    init = 1'b0;
  endtask

  task automatic give_ok(input logic [31:0] a, input logic [31:0] l, input logic v1,
                         input logic [31:0] o1, input logic v2, input logic [31:0] o2,
                         input logic with_fail);
    ip_in = a; lease_s = l; t1_val = v1; t1_s = o1; t2_val = v2; t2_s = o2;
    dora_ok = 1'b1;
    dora_fail = with_fail;
    exp_q.push_back(a);
    step();
    dora_ok = 1'b0;
    dora_fail = 1'b0;
    bcyc = cyc;
    chk("ok_state", state, ST_BOUND);
    chk("ok_ip_val", ip_val, 1);
    chk("ok_ip", ip, exp_q.pop_front());
  endtask

  task automatic run_to(input logic [2:0] s, input bit fail_starts, input int budget);
    int n;
    n = 0;
    while (state !== s && n < budget) begin
      dora_fail = fail_starts && dora_start;
      step();
      n++;
    end
    dora_fail = 1'b0;
  endtask

  task automatic backoff_check(input string tag, input int k);
    int d, w;
    w = bo_w(k);
    d = 0;
    while (state === ST_BO && d < 1000) begin
      d++;
      step();
    end
    chk(tag, (d > (w - 1) * TD) && (d <= w * TD), 1);
    chk({tag, "_acq"}, state, ST_ACQ);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int l, t1, t2, bad;
    logic [31:0] rl, o1, o2;
    logic v1, v2;

    // reset
    repeat (3) step();
    chk("rst_state", state, ST_IDLE);
    chk("rst_outs", {dora_start, ip_val, renewing, expired, fail}, 0);
    chk("rst_ip", ip, 0);
    rst = 1'b0;
    step();
    dora_ok = 1'b1;
    step();
    dora_ok = 1'b0;
    chk("idle_ignores_ok", state, ST_IDLE);

    // 1: init -> start latency, bind lease 16, renew at 8 s
    do_init();
    chk("init_acq", state, ST_ACQ);
    chk("start_lat1", dora_start, 0);
    step();
    chk("start_lat2", dora_start, 1);
    repeat (9) step();
    chk("start_single", dora_start, 0);
    give_ok($urandom, 32'd16, 0, 0, 0, 0, 0);
    model_times(32'd16, 0, 0, 0, 0, l, t1, t2);
    run_to(ST_RENEW, 0, 500);
    chk("renew_state", state, ST_RENEW);
    chk("renew_time", cyc - bcyc, t1 * TD);
    chk("renewing", renewing, 1);
    step();
    chk("renew_start", dora_start, 1);

    // ok on the T2 threshold tick wins
    while (cyc - bcyc < t2 * TD - 1) step();
    rl = $urandom_range(40, 12);
    give_ok($urandom, rl, 0, 0, 0, 0, 0);
    model_times(rl, 0, 0, 0, 0, l, t1, t2);
    run_to(ST_RENEW, 0, 500);
    chk("renew2_time", cyc - bcyc, t1 * TD);

    // 2: every renew/rebind fails -> rebind, expiry, reacquire
    run_to(ST_REBIND, 1, 2000);
    chk("rebind_state", state, ST_REBIND);
    chk("rebind_time", cyc - bcyc, t2 * TD);
    run_to(ST_ACQ, 1, 2000);
    chk("expire_state", state, ST_ACQ);
    chk("expire_time", cyc - bcyc, l * TD);
    chk("expired_pulse", expired, 1);
    chk("expire_ip_val", ip_val, 0);
    step();
    chk("expired_one_cycle", expired, 0);
    chk("expire_start", dora_start, 1);

    // 3: ACQUIRE failures with backoff, then FAILED
    for (int k = 1; k <= RET; k++) begin
      dora_fail = 1'b1;
      step();
      dora_fail = 1'b0;
      if (k < RET) begin
        chk("acq_fail_bo", state, ST_BO);
        backoff_check("backoff_len", k);
        step();
        chk("bo_start", dora_start, 1);
      end else begin
        chk("failed_state", state, ST_FAILED);
        chk("failed_flag", fail, 1);
        chk("failed_ip_val", ip_val, 0);
      end
    end
    repeat (5) step();
    dora_ok = 1'b1;
    step();
    dora_ok = 1'b0;
    chk("failed_ignores_ok", state, ST_FAILED);
    do_init();
    chk("failed_init", state, ST_ACQ);
    chk("failed_cleared", fail, 0);
    step();
    chk("failed_init_start", dora_start, 1);
    dora_fail = 1'b1;
    step();
    dora_fail = 1'b0;
    chk("retry_cleared", state, ST_BO);
    backoff_check("backoff_after_init", 1);
    step();

    // 4+5: invalid T1/T2 with simultaneous ok+fail
    give_ok($urandom, 32'd16, 1, 32'd10, 1, 32'd5, 1);
    model_times(32'd16, 1, 32'd10, 1, 32'd5, l, t1, t2);
    run_to(ST_RENEW, 0, 500);
    chk("bad_opt_renew", cyc - bcyc, t1 * TD);
    run_to(ST_REBIND, 1, 500);
    chk("bad_opt_rebind", cyc - bcyc, t2 * TD);
    give_ok($urandom, 32'd20, 0, 0, 0, 0, 0);
    repeat (3) step();
    do_init();
    chk("init_bound_state", state, ST_ACQ);
    chk("init_bound_ip_val", ip_val, 0);

    // randomized leases and options, full lifecycle to expiry
    for (int it = 0; it < 4; it++) begin
      step();
      chk("rand_start", dora_start, 1);
      rl = $urandom_range(48, 16);
      v1 = 1'($urandom_range(1, 0));
      v2 = 1'($urandom_range(1, 0));
      o1 = $urandom_range(rl + 4, 1);
      o2 = $urandom_range(rl + 4, 1);
      give_ok($urandom, rl, v1, o1, v2, o2, 0);
      model_times(rl, v1, o1, v2, o2, l, t1, t2);
      run_to(ST_RENEW, 0, 500);
      chk("rand_renew", cyc - bcyc, t1 * TD);
      run_to(ST_REBIND, 1, 500);
      chk("rand_rebind", cyc - bcyc, t2 * TD);
      run_to(ST_ACQ, 1, 500);
      chk("rand_expire", cyc - bcyc, l * TD);
      chk("rand_expired", expired, 1);
    end

    // 6: infinite lease, then reset mid-RENEW
    step();
    give_ok($urandom, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    bad = 0;
    repeat (1000 * TD) begin
      step();
      if (state !== ST_BOUND) bad++;
    end
    chk("inf_stays_bound", bad, 0);
    do_init();
    step();
    give_ok($urandom, 32'd16, 0, 0, 0, 0, 0);
    run_to(ST_RENEW, 0, 500);
    chk("pre_rst_renew", state, ST_RENEW);
    repeat (3) step();
    rst = 1'b1;
    #1;
    chk("rst_mid_state", state, ST_IDLE);
    chk("rst_mid_outs", {dora_start, ip_val, renewing, expired, fail}, 0);
    chk("rst_mid_ip", ip, 0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_idle", state, ST_IDLE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
